// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that borrows the shared
// EX-stage ALU (one add/subtract per cycle) and commits a 2*WIDTH-bit result
// into the architectural HI/LO registers.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV via op[1]).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ALU released, MTHI/MTLO accepted, waiting for start
// MUL    | shift-add iteration, one ALU add per cycle
// DIV    | restoring-divide iteration, one ALU subtract per cycle
// FIX_LO | signed only: negate low half (0 - lo) through the ALU
// FIX_HI | signed only: finish 64-bit negate or negate remainder

`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 32
`endif

module muldiv_ctrl #(
   parameter int WIDTH = `REGISTER_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_own,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_MUL    = 3'd1;
   localparam logic [2:0] S_DIV    = 3'd2;
`ifdef MULDIV_SIGNED_EN
   localparam logic [2:0] S_FIX_LO = 3'd3;
   localparam logic [2:0] S_FIX_HI = 3'd4;
`endif

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] qr_q, qr_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] r_shift;
   logic             carry;

`ifdef MULDIV_SIGNED_EN
   logic a_neg, b_neg;
   logic neg_lo_q, neg_lo_d;
   logic neg_hi_q, neg_hi_d;
   logic is_div_q, is_div_d;

   // Local negator turns signed operands into magnitudes at accept time so
   // the iteration core stays purely unsigned.
   assign a_neg = op[1] & src_a[WIDTH-1];
   assign b_neg = op[1] & src_b[WIDTH-1];
   assign a_mag = a_neg ? (WIDTH'(0) - src_a) : src_a;
   assign b_mag = b_neg ? (WIDTH'(0) - src_b) : src_b;
`else
   logic unused_op_sign;
   assign unused_op_sign = op[1];
   assign a_mag = src_a;
   assign b_mag = src_b;
`endif

   assign r_shift = {acc_q[WIDTH-2:0], qr_q[WIDTH-1]};
   assign carry   = (alu_result < alu_a);

   // Next-state, datapath and ALU-borrow logic
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      qr_d     = qr_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = 3'b000;
`ifdef MULDIV_SIGNED_EN
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      is_div_d = is_div_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = CW'(WIDTH - 1);
               opnd_d  = op[0] ? b_mag : a_mag;
               qr_d    = op[0] ? a_mag : b_mag;
               state_d = op[0] ? S_DIV : S_MUL;
`ifdef MULDIV_SIGNED_EN
               neg_lo_d = a_neg ^ b_neg;
               neg_hi_d = op[0] ? a_neg : (a_neg ^ b_neg);
               is_div_d = op[0];
`endif
            end
         end
         S_MUL: begin
            alu_a    = acc_q;
            alu_b    = qr_q[0] ? opnd_q : '0;
            alu_ctrl = ALU_ADD;
            acc_d    = {carry, alu_result[WIDTH-1:1]};
            qr_d     = {alu_result[0], qr_q[WIDTH-1:1]};
         end
         S_DIV: begin
            alu_a    = r_shift;
            alu_b    = opnd_q;
            alu_ctrl = ALU_SUB;
            if (acc_q[WIDTH-1] | (r_shift >= opnd_q)) begin
               acc_d = alu_result;
               qr_d  = {qr_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = r_shift;
               qr_d  = {qr_q[WIDTH-2:0], 1'b0};
            end
         end
`ifdef MULDIV_SIGNED_EN
         S_FIX_LO: begin
            alu_b    = qr_q;
            alu_ctrl = ALU_SUB;
            if (neg_lo_q) qr_d = alu_result;
            state_d  = S_FIX_HI;
         end
         S_FIX_HI: begin
            // -{hi,lo} = {~hi + (lo==0), -lo}; the remainder alone is ~rem + 1
            alu_a    = ~acc_q;
            alu_b    = is_div_q ? WIDTH'(1) : {{(WIDTH-1){1'b0}}, (qr_q == '0)};
            alu_ctrl = ALU_ADD;
            if (neg_hi_q) acc_d = alu_result;
            hi_d     = acc_d;
            lo_d     = qr_q;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if ((state_q == S_MUL) || (state_q == S_DIV)) begin
         if (cnt_q == '0) begin
`ifdef MULDIV_SIGNED_EN
            if (neg_lo_q | neg_hi_q) begin
               state_d = S_FIX_LO;
            end else begin
               hi_d    = acc_d;
               lo_d    = qr_d;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
`else
            hi_d    = acc_d;
            lo_d    = qr_d;
            done_d  = 1'b1;
            state_d = S_IDLE;
`endif
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end

      if (cancel) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end

      // Commits only happen outside IDLE, so MTHI/MTLO never collide with one.
      if (state_q == S_IDLE) begin
         if (wr_hi) hi_d = wr_data;
         if (wr_lo) lo_d = wr_data;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         qr_q     <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         is_div_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         qr_q     <= qr_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
`ifdef MULDIV_SIGNED_EN
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         is_div_q <= is_div_d;
`endif
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign alu_own = busy;
   assign done    = done_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = '0, src_b = '0;
   logic        cancel = 1'b0;
   logic        wr_hi = 1'b0, wr_lo = 1'b0;
   logic [31:0] wr_data = '0;
   logic        busy, done, alu_own;
   logic [31:0] hi, lo, alu_a, alu_b, alu_result;
   logic [2:0]  alu_ctrl;

   int checks = 0;
   int errors = 0;

   muldiv_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .cancel(cancel),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_own(alu_own),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // Shared EX-stage ALU stand-in
   always_comb begin
      case (alu_ctrl)
         3'b010:  alu_result = alu_a + alu_b;
         3'b110:  alu_result = alu_a - alu_b;
         3'b000:  alu_result = alu_a & alu_b;
         3'b001:  alu_result = alu_a | alu_b;
         default: alu_result = 32'h0;
      endcase
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: magnitude arithmetic, then sign fix-up; latency 32, +2 if any
   // negation is applied.
   function automatic void model(input logic [1:0] o, input logic [31:0] a, b,
                                 output logic [31:0] eh, el, output int elat);
      logic sgn, sa, sb;
      logic [31:0] ma, mb, q, r;
      logic [63:0] p;
      sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn = o[1];
`endif
      sa = sgn & a[31];
      sb = sgn & b[31];
      ma = sa ? -a : a;
      mb = sb ? -b : b;
      elat = 32;
      if (!o[0]) begin
         p = 64'(ma) * 64'(mb);
         if (sa ^ sb) begin
            p = -p;
            elat = 34;
         end
         eh = p[63:32];
         el = p[31:0];
      end else begin
         if (mb == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
         end else begin
            q = ma / mb;
            r = ma % mb;
         end
         if (sa ^ sb) q = -q;
         if (sa) r = -r;
         if ((sa ^ sb) | sa) elat = 34;
         eh = r;
         el = q;
      end
   endfunction

   // Launch one operation (assumes DUT is idle or in its done cycle) and check
   // it against the model; returns what was observed for directed checks.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, b, input string name,
                         output logic [31:0] got_hi, got_lo, output int lat);
      logic [31:0] eh, el;
      int elat;
      bit ctrl_ok;
      model(o, a, b, eh, el, elat);
      start = 1'b1; op = o; src_a = a; src_b = b;
      tick;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || alu_own !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: busy=%b alu_own=%b, required 1/1", name, busy, alu_own);
      end
      lat = 0;
      ctrl_ok = 1'b1;
      while (done !== 1'b1 && lat < 60) begin
         if (lat < 32 && alu_ctrl !== (o[0] ? 3'b110 : 3'b010)) ctrl_ok = 1'b0;
         tick;
         lat++;
      end
      got_hi = hi;
      got_lo = lo;
      checks++;
      if (lat !== elat) begin
         errors++;
         $display("FAIL %s latency: got %0d, required %0d", name, lat, elat);
      end
      checks++;
      if (hi !== eh || lo !== el) begin
         errors++;
         $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, eh, el);
      end
      checks++;
      if (busy !== 1'b0 || alu_own !== 1'b0) begin
         errors++;
         $display("FAIL %s done-cycle busy: busy=%b alu_own=%b, required 0/0", name, busy, alu_own);
      end
      checks++;
      if (!ctrl_ok) begin
         errors++;
         $display("FAIL %s alu_ctrl during iterations: wrong code seen, required %b",
                  name, o[0] ? 3'b110 : 3'b010);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      tick;
      checks++;
      if ({busy, done, alu_own, hi, lo, alu_a, alu_b, alu_ctrl} !== '0) begin
         errors++;
         $display("FAIL reset outputs: busy=%b done=%b own=%b hi=%h lo=%h a=%h b=%h ctrl=%b, required all 0",
                  busy, done, alu_own, hi, lo, alu_a, alu_b, alu_ctrl);
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_directed;
      logic [31:0] h, l;
      int lat;
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max", h, l, lat);
      checks++;
      if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001 || lat != 32) begin
         errors++;
         $display("FAIL mul_max spec: hi=%h lo=%h lat=%0d, required fffffffe/00000001/32", h, l, lat);
      end
      tick;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done pulse width: done=%b one cycle later, required 0", done);
      end
      run_op(2'b01, 32'd100, 32'd7, "div_100_7", h, l, lat);
      checks++;
      if (l !== 32'd14 || h !== 32'd2) begin
         errors++;
         $display("FAIL div_100_7 spec: lo=%0d hi=%0d, required 14/2", l, h);
      end
      run_op(2'b01, 32'h1234, 32'h0, "div_by_zero", h, l, lat);
      checks++;
      if (l !== 32'hFFFF_FFFF || h !== 32'h0000_1234) begin
         errors++;
         $display("FAIL div_by_zero spec: lo=%h hi=%h, required ffffffff/00001234", l, h);
      end
      tick;
   endtask

   task automatic test_unsigned_op1;
`ifndef MULDIV_SIGNED_EN
      logic [31:0] h, l;
      int lat;
      run_op(2'b10, 32'hFFFF_FFFD, 32'd5, "op1_ignored", h, l, lat);
      checks++;
      if (h !== 32'd4 || l !== 32'hFFFF_FFF1 || lat != 32) begin
         errors++;
         $display("FAIL op1_ignored spec: hi=%h lo=%h lat=%0d, required 4/fffffff1/32", h, l, lat);
      end
      tick;
`endif
   endtask

   task automatic test_signed;
`ifdef MULDIV_SIGNED_EN
      logic [31:0] h, l;
      int lat;
      run_op(2'b10, 32'hFFFF_FFFD, 32'd5, "smul_neg3_5", h, l, lat);
      checks++;
      if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFF1 || lat != 34) begin
         errors++;
         $display("FAIL smul_neg3_5 spec: hi=%h lo=%h lat=%0d, required ffffffff/fffffff1/34", h, l, lat);
      end
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "sdiv_neg7_2", h, l, lat);
      checks++;
      if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sdiv_neg7_2 spec: lo=%h hi=%h, required fffffffd/ffffffff", l, h);
      end
      run_op(2'b10, 32'd7, 32'd5, "smul_7_5", h, l, lat);
      checks++;
      if (l !== 32'd35 || h !== 32'd0 || lat != 32) begin
         errors++;
         $display("FAIL smul_7_5 spec: hi=%h lo=%h lat=%0d, required 0/35/32", h, l, lat);
      end
      tick;
`endif
   endtask

   task automatic test_cancel;
      bit saw_done;
      wr_hi = 1'b1; wr_data = 32'h0000_AAAA;
      tick;
      wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000_5555;
      tick;
      wr_lo = 1'b0;
      checks++;
      if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
         errors++;
         $display("FAIL mthi_mtlo: hi=%h lo=%h, required 0000aaaa/00005555", hi, lo);
      end
      start = 1'b1; op = 2'b00; src_a = $urandom; src_b = $urandom;
      tick;
      start = 1'b0;
      repeat (4) tick;
      wr_lo = 1'b1; wr_data = 32'h0000_1234;
      tick;
      wr_lo = 1'b0;
      checks++;
      if (lo !== 32'h0000_5555) begin
         errors++;
         $display("FAIL wr_lo_while_busy: lo=%h, required 00005555", lo);
      end
      repeat (4) tick;
      cancel = 1'b1;
      tick;
      cancel = 1'b0;
      checks++;
      if (busy !== 1'b0 || alu_own !== 1'b0 || alu_ctrl !== 3'b000) begin
         errors++;
         $display("FAIL cancel_busy: busy=%b own=%b ctrl=%b, required 0/0/000", busy, alu_own, alu_ctrl);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) saw_done = 1'b1;
         tick;
      end
      checks++;
      if (saw_done || hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
         errors++;
         $display("FAIL cancel_result: done_seen=%b hi=%h lo=%h, required 0/0000aaaa/00005555",
                  saw_done, hi, lo);
      end
      start = 1'b1; cancel = 1'b1;
      tick;
      start = 1'b0; cancel = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_with_cancel: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] h, l;
      int lat;
      start = 1'b1; op = 2'b00; src_a = 32'h1357_9BDF; src_b = 32'h2468_ACE0;
      tick;
      start = 1'b0;
      repeat (5) tick;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, alu_own, hi, lo, alu_a, alu_b, alu_ctrl} !== '0) begin
         errors++;
         $display("FAIL reset_mid outputs: busy=%b done=%b own=%b hi=%h lo=%h a=%h b=%h ctrl=%b, required all 0",
                  busy, done, alu_own, hi, lo, alu_a, alu_b, alu_ctrl);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick;
      run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_0123, "after_reset", h, l, lat);
      tick;
   endtask

   task automatic test_back_to_back;
      logic [31:0] h, l, a, b;
      logic [1:0] o;
      int lat;
      for (int i = 0; i < 16; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'h0;
            1: b = 32'($urandom_range(1, 255));
            2: b = a ^ 32'($urandom_range(0, 15));
            default: b = $urandom;
         endcase
         run_op(o, a, b, "random_b2b", h, l, lat);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_directed;
      test_unsigned_op1;
      test_signed;
      test_cancel;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide controller that borrows the shared 3-bit-ctrl ALU for the CPU's MULT/DIV instructions, sequencing one add or subtract per cycle and committing the 64-bit result to the architectural HI/LO registers. It sits beside the EX stage. While it owns the ALU it raises `alu_own` so the EX-stage operand mux hands the ALU over, and the pipeline stalls on `busy`.

## Interface
- `WIDTH`, default `` `REGISTER_WIDTH `` (32): operand, HI and LO width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: launch an operation; accepted only in IDLE.
- `op` in 2: `op[0]`: 0 = multiply, 1 = divide. `op[1]`: 1 = signed (only with SIGNED_EN), else ignored.
- `src_a`, `src_b` in WIDTH: multiplicand/multiplier or dividend/divisor; sampled on accept.
- `cancel` in 1: pipeline flush; aborts any operation.
- `wr_hi`, `wr_lo` in 1, `wr_data` in WIDTH: MTHI/MTLO writes.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO are committed.
- `hi`, `lo` out WIDTH: architectural HI/LO.
- `alu_own` out 1: ALU mux select, equal to `busy`.
- `alu_a`, `alu_b` out WIDTH, `alu_ctrl` out 3: ALU operands and op code.
- `alu_result` in WIDTH: combinational ALU result.

## Operation
- **States:**
  - IDLE → MUL or DIV on accepted `start`.
  - MUL/DIV → FIX_LO after 32 iterations when signed correction is needed.
  - Otherwise MUL/DIV → IDLE, pulsing `done`.
  - FIX_LO → FIX_HI → IDLE, pulsing `done`.
- **Working registers:** `acc`, `qr`, `opnd`, and iteration count `cnt` (0..WIDTH-1). HI/LO change only at commit or on MTHI/MTLO.
- **Multiply (shift-add):**
  - `alu_a = acc`, `alu_b = qr[0] ? opnd : 0`, `alu_ctrl = 3'b010`.
  - `carry = (alu_result < alu_a)`.
  - `{acc, qr} <= {carry, alu_result, qr} >> 1`.
  - Final: HI = `acc`, LO = `qr`.
- **Divide (restoring):**
  - `r' = {acc[W-2:0], qr[W-1]}`, `t = acc[W-1]`.
  - `alu_a = r'`, `alu_b = opnd`, `alu_ctrl = 3'b110`.
  - If `t | (r' >= opnd)`: `acc <= alu_result`, quotient bit = 1. Else `acc <= r'`, quotient bit = 0.
  - `qr <= {qr[W-2:0], bit}`.
  - Final: HI = remainder, LO = quotient.
  - Divide by zero needs no special case: LO = all ones, HI = dividend.
- **ALU outputs when not owning:** `alu_a = alu_b = 0`, `alu_ctrl = 3'b000`.
- **MTHI/MTLO:** `wr_hi`/`wr_lo` write `wr_data` when `busy` = 0. Ignored while busy. A commit and a write cannot coincide.
- **`cancel`:** next state IDLE, no `done`, HI/LO unchanged. `cancel` with `start` in the same IDLE cycle: start dropped.
- **`start` while busy:** ignored.

## Timing
- **Reset:** all registers zero, so `busy`, `done`, `alu_own`, `hi`, `lo`, `alu_a`, `alu_b`, `alu_ctrl` = 0. State = IDLE. Reset mid-operation discards it immediately.
- **Accept:** `start` high in IDLE at edge E0 latches operands. `busy` and `alu_own` are high from E0.
- **Iterations:** edges E1..E32.
- **Unsigned commit:** at E32. `done` = 1 and `busy` = 0 in the cycle after E32. HI/LO valid from then. Latency 32 cycles, back-to-back `start` allowed in the `done` cycle.
- **Signed correction:** adds 2 cycles (FIX_LO, FIX_HI). Latency 34.
- `alu_result` is consumed in the same cycle it is driven; no registered ALU path.

## Configuration
- **`MULDIV_SIGNED_EN` defined:** `op[1]` = 1 selects signed operation.
  - On accept, operands are converted to magnitude by a local negator. Signs are recorded.
  - Multiply: negate the 64-bit result if the signs differ.
  - Divide: negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - FIX_LO: `alu_ctrl = 110`, `a = 0`, `b = lo-part`.
  - FIX_HI: `alu_ctrl = 010`, `a = ~hi-part`, `b = (lo-part == 0)` for a 64-bit negate, or `0 - rem` for the remainder.
  - FIX states are skipped when no negation is needed.
- **`MULDIV_SIGNED_EN` absent:** `op[1]` is ignored, all operations are unsigned, and FIX states and sign logic are not compiled.

## Test plan
- Unsigned multiply `0xFFFFFFFF` × `0xFFFFFFFF` → `done` 32 cycles after accept; HI = `0xFFFFFFFE`, LO = `0x00000001`; `alu_ctrl` = `010` each iteration.
- Unsigned divide 100 / 7 → LO = 14, HI = 2. Divide `0x1234` / 0 → LO = `0xFFFFFFFF`, HI = `0x00001234`.
- Preload HI = `0xAAAA` via `wr_hi`, start a multiply, assert `cancel` at iteration 10 → `busy` low next cycle, no `done`, HI = `0xAAAA`. `wr_lo` while busy → LO unchanged.
- Reset: assert `rst_n` = 0 at iteration 5 → all outputs 0 immediately. A new `start` after release completes normally.
- With `MULDIV_SIGNED_EN`:
  - −3 × 5 → HI = `0xFFFFFFFF`, LO = `0xFFFFFFF1`, latency 34.
  - −7 / 2 → LO = `0xFFFFFFFD`, HI = `0xFFFFFFFF`.
  - 7 × 5 signed → latency 32.
- Without the macro: `op` = `2'b10`, `src_a` = `0xFFFFFFFD`, `src_b` = 5 → unsigned product HI = 4, LO = `0xFFFFFFF1`.
